fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a programme counter, a fixed-latency instruction-memory request port and a DEPTH-entry prefetch queue of {PC, instruction} pairs. It sits between instruction memory and decode. It replaces the single pipeline register with three additions: decode backpressure (valid/ready), branch redirect with flush of queued and in-flight fetches, and up to one instruction per cycle sustained throughput.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request port and decode-side head handshake.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [DATA_W-1:0] i_imem_data;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data_Instr;
  logic [ADDR_W-1:0] o_addr_PC;
  logic [CNT_W-1:0]  o_count;

  // Fetch stage side
  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_data_Instr, o_addr_PC, o_count,
    input  i_imem_data, i_redirect, i_redirect_pc, i_ready
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_data_Instr, o_addr_PC, o_count,
    output i_imem_data, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: PC, single-cycle-latency imem request, DEPTH-entry {PC, instr} prefetch queue
// with decode backpressure and branch redirect flush.
module fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inf_addr_q, inf_addr_d;

  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];

  logic              valid_c, pop_c, push_c, issue_c;
  logic [OCC_W-1:0]  occ_c;

  // Handshake decode; the pop credit lets a full queue keep issuing while decode drains it.
  // Request is also held low during reset so every output reads 0 while i_rst is high.
  always_comb begin
    valid_c = (count_q != '0);
    pop_c   = valid_c & bus.i_ready & ~bus.i_redirect;
    push_c  = inflight_q & ~bus.i_redirect;
    occ_c   = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop_c);
    issue_c = ~i_rst & ~bus.i_redirect & (occ_c < OCC_W'(DEPTH));
  end

  // Next-state: redirect flushes queue and in-flight fetch and reloads the PC.
  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    inf_addr_d = inf_addr_q;
    if (bus.i_redirect) begin
      pc_d       = bus.i_redirect_pc;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
      if (issue_c) begin
        pc_d       = pc_q + ADDR_W'(PC_STEP);
        inflight_d = 1'b1;
        inf_addr_d = pc_q;
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      inf_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      inf_addr_q <= inf_addr_d;
    end
  end

  // Queue storage; contents are don't-care until count covers them, so no reset.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      pc_mem_q[wr_ptr_q]    <= inf_addr_q;
      instr_mem_q[wr_ptr_q] <= bus.i_imem_data;
    end
  end

  assign bus.o_imem_req   = issue_c;
  assign bus.o_imem_addr  = pc_q;
  assign bus.o_valid      = valid_c;
  assign bus.o_data_Instr = valid_c ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.o_addr_PC    = valid_c ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.o_count      = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirect, async reset, PC wrap.
module tb_fetch_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus0 ();
  fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus1 ();

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4))
    dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4))
    dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; memory returns addr^K for the address presented before the edge.
  task automatic tick();
    logic [31:0] a0, a1;
    a0 = bus0.o_imem_addr;
    a1 = bus1.o_imem_addr;
    @(posedge clk);
    #1;
    bus0.i_imem_data = a0 ^ K;
    bus1.i_imem_data = a1 ^ K;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus0.i_ready = 1'b1; bus0.i_redirect = 1'b0; bus0.i_redirect_pc = '0; bus0.i_imem_data = '0;
    bus1.i_ready = 1'b1; bus1.i_redirect = 1'b0; bus1.i_redirect_pc = '0; bus1.i_imem_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", 32'(bus0.o_valid), 32'd0);
    chk("rst_count", 32'(bus0.o_count), 32'd0);
    chk("rst_data",  bus0.o_data_Instr, 32'd0);
    chk("rst_pc",    bus0.o_addr_PC, 32'd0);
    chk("rst_req",   32'(bus0.o_imem_req), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req",   32'(bus0.o_imem_req), 32'd1);
    chk("rel_addr",  bus0.o_imem_addr, 32'h0);
    chk("rel_addr1", bus1.o_imem_addr, 32'hFFFF_FFF8);

    tick();
    #1;
    chk("c1_valid", 32'(bus0.o_valid), 32'd0);
    chk("c1_addr",  bus0.o_imem_addr, 32'h4);
    tick();

    // Stream with ready high: one head per cycle from cycle 2, plus PC wrap on dut1
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("stream_valid", 32'(bus0.o_valid), 32'd1);
      chk("stream_pc",    bus0.o_addr_PC, 32'(4 * k));
      chk("stream_data",  bus0.o_data_Instr, 32'(4 * k) ^ K);
      if (k < 4) chk("wrap_pc", bus1.o_addr_PC, 32'hFFFF_FFF8 + 32'(4 * k));
      tick();
    end

    // Backpressure from steady state: requests stop once count+inflight reaches 4
    bus0.i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_req",   32'(bus0.o_imem_req), 32'((k < 2) ? 1 : 0));
      chk("bp_count", 32'(bus0.o_count), 32'((k < 3) ? k + 1 : 4));
      chk("bp_head",  bus0.o_addr_PC, 32'h18);
      tick();
    end

    // Release: pop credit re-enables request at once, heads continue without a gap
    bus0.i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k == 0) chk("bp_rel_req", 32'(bus0.o_imem_req), 32'd1);
      chk("drain_pc",   bus0.o_addr_PC, 32'h18 + 32'(4 * k));
      chk("drain_data", bus0.o_data_Instr, (32'h18 + 32'(4 * k)) ^ K);
      tick();
    end

    // Redirect with ready high, count=3 and a fetch in flight
    bus0.i_redirect    = 1'b1;
    bus0.i_redirect_pc = 32'h100;
    #1;
    chk("redir_count", 32'(bus0.o_count), 32'd3);
    chk("redir_head",  bus0.o_addr_PC, 32'h30);
    chk("redir_req",   32'(bus0.o_imem_req), 32'd0);
    tick();
    bus0.i_redirect = 1'b0;
    #1;
    chk("post_redir_valid", 32'(bus0.o_valid), 32'd0);
    chk("post_redir_count", 32'(bus0.o_count), 32'd0);
    chk("post_redir_addr",  bus0.o_imem_addr, 32'h100);
    chk("post_redir_req",   32'(bus0.o_imem_req), 32'd1);
    tick();
    #1;
    chk("redir2_valid", 32'(bus0.o_valid), 32'd0);
    chk("redir2_addr",  bus0.o_imem_addr, 32'h104);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("redir_stream_valid", 32'(bus0.o_valid), 32'd1);
      chk("redir_stream_pc",    bus0.o_addr_PC, 32'h100 + 32'(4 * k));
      chk("redir_stream_data",  bus0.o_data_Instr, (32'h100 + 32'(4 * k)) ^ K);
      tick();
    end

    // Fill, then async reset pulse between edges
    bus0.i_ready = 1'b0;
    repeat (6) tick();
    #1;
    chk("full_count", 32'(bus0.o_count), 32'd4);
    chk("full_req",   32'(bus0.o_imem_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus0.o_valid), 32'd0);
    chk("arst_count", 32'(bus0.o_count), 32'd0);
    chk("arst_data",  bus0.o_data_Instr, 32'd0);
    chk("arst_pc",    bus0.o_addr_PC, 32'd0);
    chk("arst_req",   32'(bus0.o_imem_req), 32'd0);
    chk("arst_addr",  bus0.o_imem_addr, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("arel_req",  32'(bus0.o_imem_req), 32'd1);
    chk("arel_addr", bus0.o_imem_addr, 32'h0);
    bus0.i_ready = 1'b1;
    tick();
    #1;
    chk("arel_c1_valid", 32'(bus0.o_valid), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("restart_pc",   bus0.o_addr_PC, 32'(4 * k));
      chk("restart_data", bus0.o_data_Instr, 32'(4 * k) ^ K);
      chk("restart_pc1",  bus1.o_addr_PC, 32'hFFFF_FFF8 + 32'(4 * k));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
